// File: rtl/fpnew_pkg.sv
// Shared FPU types and helpers used by the opgroup output arbitration path.
package fpnew_pkg;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

  // Index width for an n-entry selector; a single entry still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fpnew_rr_pick.sv
// Combinational round-robin search: first valid index at or above the pointer, wrapping.
module fpnew_rr_pick
  import fpnew_pkg::*;
#(
  parameter int unsigned NumSlices = 4,
  localparam int unsigned IdxW = idx_width(NumSlices)
) (
  input  logic [NumSlices-1:0] valid_i,
  input  logic [IdxW-1:0]      ptr_i,
  output logic [NumSlices-1:0] grant_o,
  output logic [IdxW-1:0]      idx_o,
  output logic                 any_valid_o
);

  int unsigned     cand_sum;
  logic [IdxW-1:0] cand;

  always_comb begin
    // NOTE: every variable gets a default before the search so no path infers a latch.
    grant_o     = '0;
    idx_o       = '0;
    any_valid_o = 1'b0;
    cand_sum    = 0;
    cand        = '0;
    for (int unsigned off = 0; off < NumSlices; off++) begin
      cand_sum = 32'(ptr_i) + off;
      if (cand_sum >= NumSlices) cand_sum = cand_sum - NumSlices;
      cand = cand_sum[IdxW-1:0];
      if (!any_valid_o && valid_i[cand]) begin
        any_valid_o   = 1'b1;
        idx_o         = cand;
        grant_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpnew_opgroup_out_arb.sv
// Round-robin merge of per-format slice outputs into one registered valid/ready result stage.
module fpnew_opgroup_out_arb
  import fpnew_pkg::*;
#(
  parameter int unsigned NumSlices = 4,
  parameter int unsigned Width     = 32,
  parameter type         TagType   = logic
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            clr_i,
  input  logic [NumSlices-1:0][Width-1:0] slice_result_i,
  input  status_t [NumSlices-1:0]         slice_status_i,
  input  logic [NumSlices-1:0]            slice_ext_bit_i,
  input  TagType [NumSlices-1:0]          slice_tag_i,
  input  logic [NumSlices-1:0]            slice_valid_i,
  output logic [NumSlices-1:0]            slice_ready_o,
  input  logic                            flush_i,
  output logic [Width-1:0]                result_o,
  output status_t                         status_o,
  output logic                            extension_bit_o,
  output TagType                          tag_o,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic                            busy_o
);

  localparam int unsigned IdxW = idx_width(NumSlices);

  logic [IdxW-1:0]      ptr_q;
  logic [IdxW-1:0]      win_idx;
  logic [NumSlices-1:0] win_onehot;
  logic                 any_valid;
  logic                 ld;
  logic                 xfer;

  fpnew_rr_pick #(
    .NumSlices(NumSlices)
  ) i_rr_pick (
    .valid_i    (slice_valid_i),
    .ptr_i      (ptr_q),
    .grant_o    (win_onehot),
    .idx_o      (win_idx),
    .any_valid_o(any_valid)
  );

  // The output stage can accept when empty or draining, unless a flush is killing it.
  assign ld            = (~out_valid_o | out_ready_i) & ~flush_i;
  assign xfer          = ld & any_valid;
  assign slice_ready_o = win_onehot & {NumSlices{ld}};
  assign busy_o        = out_valid_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst_i) begin
      out_valid_o     <= 1'b0;
      result_o        <= '0;
      status_o        <= '0;
      extension_bit_o <= 1'b0;
      tag_o           <= '0;
      ptr_q           <= '0;
    end else if (clr_i) begin
      out_valid_o     <= 1'b0;
      result_o        <= '0;
      status_o        <= '0;
      extension_bit_o <= 1'b0;
      tag_o           <= '0;
      ptr_q           <= '0;
    end else if (xfer) begin
      out_valid_o     <= 1'b1;
      result_o        <= slice_result_i[win_idx];
      status_o        <= slice_status_i[win_idx];
      extension_bit_o <= slice_ext_bit_i[win_idx];
      tag_o           <= slice_tag_i[win_idx];
      ptr_q           <= IdxW'(rr_next(32'(win_idx), NumSlices));
    end else if (flush_i || out_ready_i) begin
      out_valid_o     <= 1'b0;
    end
  end

endmodule
